// File: rtl/arm_cs1_bridge.sv
// -----------------------------------------------------------------------------
// arm_cs1_bridge
//
// Slave bridge between the ARM926 chip-select 1 asynchronous bus and the
// SYS_CLK fabric. The ARM strobes are synchronized, and each access is
// qualified by a setup delay. A small 32-bit register file is then decoded,
// and every access is handshaked with ARM_DTACK. Pushbutton rising edges can
// raise ARM_IRQ. The MZB_D tristate lives in the parent, built from
// ARM_D_OUT / ARM_D_OE.
//
// Optional feature macro: ECE453_PB_IRQ_EN
//   defined   : IRQ_PEND (W1C), IRQ_MASK, pushbutton edge detect, ARM_IRQ.
//   undefined : offsets 3/4 read 0 and ignore writes, ARM_IRQ is tied 0.
//
// Parameters
//   ADDR_W     word-address bits decoded from ARM_A[ADDR_W+1:2]
//   SETUP_CYC  cycles synchronized CS must stay low before sampling (1..15)
//
// Ports
//   SYS_CLK    in   1   system clock, the only clock
//   SYS_RST_N  in   1   synchronous active-low reset
//   ARM_A      in   24  ARM address bus
//   ARM_D_IN   in   32  ARM write data
//   ARM_D_OUT  out  32  read data toward MZB_D
//   ARM_D_OE   out  1   parent drives MZB_D when high
//   ARM_BE_B   in   4   active-low byte enables, bit n = byte n
//   ARM_CS1_B  in   1   active-low chip select
//   ARM_OE_B   in   1   active-low output enable
//   ARM_RW     in   1   1 = read, 0 = write
//   ARM_DTACK  out  1   transfer acknowledge
//   ARM_IRQ    out  1   registered interrupt request
//   PB         in   5   raw pushbuttons
//   DIP_SW     in   8   raw switches
//   LED        out  8   LED register contents
// -----------------------------------------------------------------------------
module arm_cs1_bridge #(
    parameter int ADDR_W    = 3,
    parameter int SETUP_CYC = 2
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST_N,
    input  logic [23:0] ARM_A,
    input  logic [31:0] ARM_D_IN,
    output logic [31:0] ARM_D_OUT,
    output logic        ARM_D_OE,
    input  logic [3:0]  ARM_BE_B,
    input  logic        ARM_CS1_B,
    input  logic        ARM_OE_B,
    input  logic        ARM_RW,
    output logic        ARM_DTACK,
    output logic        ARM_IRQ,
    input  logic [4:0]  PB,
    input  logic [7:0]  DIP_SW,
    output logic [7:0]  LED
);

    localparam logic [31:0] ID_VALUE   = 32'h0453_B001;
    localparam logic [3:0]  SETUP_LAST = 4'(SETUP_CYC - 1);

    typedef enum logic [2:0] {
        ST_RELEASE,
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_ACK
    } state_t;

    state_t      state, state_next;
    logic [3:0]  wait_cnt, wait_cnt_next;

    logic        cs_meta, cs_s, oe_meta, oe_s;
    logic [4:0]  pb_meta, pb_s;
    logic [7:0]  sw_meta, sw_s;

    logic        rw_q;
    logic [31:0] scratch;
    logic [31:0] cycle_cnt;
    logic [4:0]  irq_pend, irq_mask;
    logic [31:0] rd_data;
    logic [31:0] word_sel;
    logic [3:0]  be;
    logic        xfer, wr_en;
    logic        unused_addr_bits;

    assign word_sel = 32'(ARM_A[ADDR_W+1:2]);
    assign be       = ~ARM_BE_B;
    assign xfer     = (state == ST_XFER);
    assign wr_en    = xfer && !ARM_RW;

    // Byte-lane and high address bits are not part of the word decode.
    assign unused_addr_bits = ^{ARM_A[23:ADDR_W+2], ARM_A[1:0]};

    // Two-flop synchronizers.
    // NOTE: CS resets to "asserted" so that a cycle already in flight during
    // reset can never be mistaken for a fresh high-then-low strobe; RELEASE
    // only exits after a genuinely observed CS high.
    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            cs_meta <= 1'b0;
            cs_s    <= 1'b0;
            oe_meta <= 1'b1;
            oe_s    <= 1'b1;
            pb_meta <= '0;
            pb_s    <= '0;
            sw_meta <= '0;
            sw_s    <= '0;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the
            // previous stage's old value, which is what a synchronizer chain
            // needs; blocking here would collapse the two stages into one.
            cs_meta <= ARM_CS1_B;
            cs_s    <= cs_meta;
            oe_meta <= ARM_OE_B;
            oe_s    <= oe_meta;
            pb_meta <= PB;
            pb_s    <= pb_meta;
            sw_meta <= DIP_SW;
            sw_s    <= sw_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            state    <= ST_RELEASE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no
        // latch is inferred.
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            ST_RELEASE: if (cs_s) state_next = ST_IDLE;
            ST_IDLE: begin
                if (!cs_s) begin
                    state_next    = ST_WAIT;
                    wait_cnt_next = '0;
                end
            end
            ST_WAIT: begin
                if (cs_s)                         state_next    = ST_IDLE;
                else if (wait_cnt == SETUP_LAST)  state_next    = ST_XFER;
                else                              wait_cnt_next = wait_cnt + 4'd1;
            end
            ST_XFER:    state_next = ST_ACK;
            ST_ACK:     if (cs_s) state_next = ST_IDLE;
            default:    state_next = ST_RELEASE;
        endcase
    end

    assign ARM_DTACK = (state == ST_ACK);
    assign ARM_D_OE  = (state == ST_ACK) && rw_q && !oe_s;

    // Read multiplexer; CYCLE_CNT is taken on the edge that leaves XFER.
    always_comb begin
        rd_data = '0;
        case (word_sel)
            32'd0:   rd_data = scratch;
            32'd1:   rd_data = {24'd0, LED};
            32'd2:   rd_data = {19'd0, pb_s, sw_s};
            32'd3:   rd_data = {27'd0, irq_pend};
            32'd4:   rd_data = {27'd0, irq_mask};
            32'd5:   rd_data = cycle_cnt;
            32'd6:   rd_data = ID_VALUE;
            default: rd_data = '0;
        endcase
    end

    // Register file, read-data register and free-running cycle counter.
    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            scratch   <= '0;
            LED       <= '0;
            cycle_cnt <= '0;
            ARM_D_OUT <= '0;
            rw_q      <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (xfer) begin
                rw_q <= ARM_RW;
                if (ARM_RW) ARM_D_OUT <= rd_data;
            end
            if (wr_en && word_sel == 32'd0) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) scratch[8*b +: 8] <= ARM_D_IN[8*b +: 8];
                end
            end
            if (wr_en && word_sel == 32'd1 && be[0]) LED <= ARM_D_IN[7:0];
        end
    end

`ifdef ECE453_PB_IRQ_EN
    logic [4:0] pb_d;
    logic [4:0] pb_rise;
    logic [4:0] pend_clr;
    logic       irq_q;

    assign pb_rise  = pb_s & ~pb_d;
    assign pend_clr = (wr_en && word_sel == 32'd3 && be[0]) ? ARM_D_IN[4:0] : 5'd0;
    assign ARM_IRQ  = irq_q;

    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            pb_d     <= '0;
            irq_pend <= '0;
            irq_mask <= '0;
            irq_q    <= 1'b0;
        end else begin
            pb_d     <= pb_s;
            // A new edge overrides a simultaneous write-1-to-clear.
            irq_pend <= (irq_pend & ~pend_clr) | pb_rise;
            if (wr_en && word_sel == 32'd4 && be[0]) irq_mask <= ARM_D_IN[4:0];
            irq_q    <= |(irq_pend & irq_mask);
        end
    end
`else
    assign irq_pend = '0;
    assign irq_mask = '0;
    assign ARM_IRQ  = 1'b0;
`endif

endmodule

// File: tb/tb_arm_cs1_bridge.sv
// -----------------------------------------------------------------------------
// tb_arm_cs1_bridge
//
// Self-checking bench for arm_cs1_bridge. Directed steps cover reset values,
// byte-enabled writes, LED/STATUS, the interrupt path (when ECE453_PB_IRQ_EN
// is defined), aborted strobes and reset in the middle of an access. A block
// of random bus accesses is then compared against a register-level model.
// -----------------------------------------------------------------------------
module tb_arm_cs1_bridge;

    localparam int          SETUP_CYC = 2;
    localparam int          ACK_EDGE  = SETUP_CYC + 4;
    localparam logic [31:0] ID_VALUE  = 32'h0453_B001;

    logic        SYS_CLK = 1'b0;
    logic        SYS_RST_N;
    logic [23:0] ARM_A;
    logic [31:0] ARM_D_IN;
    logic [31:0] ARM_D_OUT;
    logic        ARM_D_OE;
    logic [3:0]  ARM_BE_B;
    logic        ARM_CS1_B;
    logic        ARM_OE_B;
    logic        ARM_RW;
    logic        ARM_DTACK;
    logic        ARM_IRQ;
    logic [4:0]  PB;
    logic [7:0]  DIP_SW;
    logic [7:0]  LED;

    arm_cs1_bridge #(.ADDR_W(3), .SETUP_CYC(SETUP_CYC)) dut (
        .SYS_CLK   (SYS_CLK),
        .SYS_RST_N (SYS_RST_N),
        .ARM_A     (ARM_A),
        .ARM_D_IN  (ARM_D_IN),
        .ARM_D_OUT (ARM_D_OUT),
        .ARM_D_OE  (ARM_D_OE),
        .ARM_BE_B  (ARM_BE_B),
        .ARM_CS1_B (ARM_CS1_B),
        .ARM_OE_B  (ARM_OE_B),
        .ARM_RW    (ARM_RW),
        .ARM_DTACK (ARM_DTACK),
        .ARM_IRQ   (ARM_IRQ),
        .PB        (PB),
        .DIP_SW    (DIP_SW),
        .LED       (LED)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model: register contents and clock edges since reset.
    logic [31:0] m_scratch;
    logic [7:0]  m_led;
    logic [4:0]  m_pend;
    logic [4:0]  m_mask;
    logic [31:0] edges_since_rst;

    always @(posedge SYS_CLK) begin
        if (!SYS_RST_N) edges_since_rst <= 32'd0;
        else            edges_since_rst <= edges_since_rst + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_scratch = '0;
        m_led     = '0;
        m_pend    = '0;
        m_mask    = '0;
    endtask

    task automatic model_write(input int off, input logic [3:0] be_b, input logic [31:0] d);
        case (off)
            0: for (int b = 0; b < 4; b++) if (!be_b[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
            1: if (!be_b[0]) m_led = d[7:0];
`ifdef ECE453_PB_IRQ_EN
            3: if (!be_b[0]) m_pend = m_pend & ~d[4:0];
            4: if (!be_b[0]) m_mask = d[4:0];
`endif
            default: ;
        endcase
    endtask

    task automatic model_pb_rise(input logic [4:0] bits);
`ifdef ECE453_PB_IRQ_EN
        m_pend = m_pend | bits;
`else
        if (bits != 5'd0) m_pend = m_pend;
`endif
    endtask

    function automatic logic [31:0] model_read(input int off, input logic [31:0] cnt);
        case (off)
            0:       return m_scratch;
            1:       return {24'd0, m_led};
            2:       return {19'd0, PB, DIP_SW};
            3:       return {27'd0, m_pend};
            4:       return {27'd0, m_mask};
            5:       return cnt;
            6:       return ID_VALUE;
            default: return 32'd0;
        endcase
    endfunction

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge SYS_CLK);
    endtask

    // One complete bus cycle. pb_at > 0 drives PB = pb_val after that many
    // edges of the access. cnt_exp is the CYCLE_CNT value a read would return.
    task automatic access(input logic rw, input int off, input logic [3:0] be_b,
                          input logic [31:0] wdata, input int pb_at, input logic [4:0] pb_val,
                          output logic [31:0] rdata, output logic [31:0] cnt_exp);
        int   n;
        logic seen;
        @(negedge SYS_CLK);
        ARM_A     = {19'($urandom), 3'(off), 2'($urandom)};
        ARM_D_IN  = wdata;
        ARM_BE_B  = be_b;
        ARM_RW    = rw;
        ARM_OE_B  = ~rw;
        ARM_CS1_B = 1'b0;
        cnt_exp   = edges_since_rst + 32'(ACK_EDGE - 1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge SYS_CLK);
            n++;
            if (n == pb_at) PB = pb_val;
            if (ARM_DTACK) seen = 1'b1;
        end
        check("dtack_latency", 32'(n), 32'(ACK_EDGE));
        rdata = ARM_D_OUT;
        if (rw) check("d_oe_in_ack", 32'(ARM_D_OE), 32'd1);
        ARM_CS1_B = 1'b1;
        ARM_OE_B  = 1'b1;
        wait_cycles(2);
        check("dtack_hold", 32'(ARM_DTACK), 32'd1);
        wait_cycles(1);
        check("dtack_release", 32'(ARM_DTACK), 32'd0);
        check("d_oe_release", 32'(ARM_D_OE), 32'd0);
    endtask

    task automatic wr(input int off, input logic [3:0] be_b, input logic [31:0] d);
        logic [31:0] rd, c;
        access(1'b0, off, be_b, d, 0, 5'd0, rd, c);
        model_write(off, be_b, d);
    endtask

    task automatic rd_chk(input string tag, input int off);
        logic [31:0] rd, c;
        access(1'b1, off, 4'b0000, 32'd0, 0, 5'd0, rd, c);
        check(tag, rd, model_read(off, c));
    endtask

    initial begin
        logic [31:0] rd, c;
        logic        seen;
        int          n;

        SYS_RST_N = 1'b0;
        ARM_A     = '0;
        ARM_D_IN  = '0;
        ARM_BE_B  = 4'hF;
        ARM_CS1_B = 1'b1;
        ARM_OE_B  = 1'b1;
        ARM_RW    = 1'b1;
        PB        = '0;
        DIP_SW    = '0;
        model_reset();

        // Reset defaults.
        wait_cycles(3);
        SYS_RST_N = 1'b1;
        @(negedge SYS_CLK);
        check("rst_dtack", 32'(ARM_DTACK), 32'd0);
        check("rst_d_oe",  32'(ARM_D_OE),  32'd0);
        check("rst_irq",   32'(ARM_IRQ),   32'd0);
        check("rst_led",   32'(LED),       32'd0);
        check("rst_d_out", ARM_D_OUT,      32'd0);
        wait_cycles(4);
        rd_chk("id_read", 6);
        access(1'b1, 6, 4'b0000, 32'd0, 0, 5'd0, rd, c);
        check("id_const", rd, 32'h0453_B001);

        // Byte-enabled writes to SCRATCH.
        wr(0, 4'b0000, 32'hDEADBEEF);
        wr(0, 4'b1010, 32'h11223344);
        access(1'b1, 0, 4'b0000, 32'd0, 0, 5'd0, rd, c);
        check("scratch_be", rd, 32'hDE22BE44);

        // LED and STATUS.
        wr(1, 4'b0000, 32'h000000A5);
        check("led_pins", 32'(LED), 32'h000000A5);
        @(negedge SYS_CLK);
        DIP_SW = 8'h3C;
        PB     = 5'b00001;
        model_pb_rise(5'b00001);
        wait_cycles(4);
        access(1'b1, 2, 4'b0000, 32'd0, 0, 5'd0, rd, c);
        check("status", rd, 32'h0000013C);
        PB = 5'd0;
        wait_cycles(4);

        // Interrupt path.
`ifdef ECE453_PB_IRQ_EN
        wr(3, 4'b0000, 32'h1F);
        wr(4, 4'b0000, 32'h04);
        wait_cycles(3);
        check("irq_idle", 32'(ARM_IRQ), 32'd0);
        PB = 5'b00100;
        model_pb_rise(5'b00100);
        wait_cycles(3);
        check("irq_before_4", 32'(ARM_IRQ), 32'd0);
        wait_cycles(1);
        check("irq_after_4", 32'(ARM_IRQ), 32'd1);
        rd_chk("pend_set", 3);
        check("pend_model", {27'd0, m_pend}, 32'h04);
        wr(3, 4'b0000, 32'h04);
        check("irq_cleared", 32'(ARM_IRQ), 32'd0);
        PB = 5'd0;
        wait_cycles(4);
        PB = 5'b00100;
        model_pb_rise(5'b00100);
        wait_cycles(5);
        PB = 5'd0;
        wait_cycles(4);
        // W1C commits on the same edge that the new PB[2] edge is detected.
        access(1'b0, 3, 4'b0000, 32'h04, 3, 5'b00100, rd, c);
        model_write(3, 4'b0000, 32'h04);
        model_pb_rise(5'b00100);
        access(1'b1, 3, 4'b0000, 32'd0, 0, 5'd0, rd, c);
        check("set_beats_clear", rd, 32'h04);
        check("irq_still_set", 32'(ARM_IRQ), 32'd1);
`else
        wr(4, 4'b0000, 32'h1F);
        PB = 5'b00100;
        wait_cycles(6);
        check("irq_tied_low", 32'(ARM_IRQ), 32'd0);
        access(1'b1, 3, 4'b0000, 32'd0, 0, 5'd0, rd, c);
        check("pend_absent", rd, 32'd0);
        access(1'b1, 4, 4'b0000, 32'd0, 0, 5'd0, rd, c);
        check("mask_absent", rd, 32'd0);
`endif
        PB = 5'd0;
        wait_cycles(4);

        // Random accesses against the model; PB stays quiet here.
        for (int i = 0; i < 24; i++) begin
            logic        rw;
            int          off;
            logic [3:0]  be_b;
            logic [31:0] d;
            rw     = 1'($urandom_range(0, 1));
            off    = int'($urandom_range(0, 7));
            be_b   = 4'($urandom_range(0, 15));
            d      = $urandom;
            DIP_SW = 8'($urandom);
            access(rw, off, be_b, d, 0, 5'd0, rd, c);
            if (rw) check($sformatf("rand_rd_off%0d", off), rd, model_read(off, c));
            else    model_write(off, be_b, d);
        end
        rd_chk("rand_scratch_final", 0);
        check("rand_led_pins", 32'(LED), 32'(m_led));
        wait_cycles(2);
        check("rand_irq_level", 32'(ARM_IRQ), 32'(|(m_pend & m_mask)));

        // Aborted strobe: CS low for only two cycles.
        @(negedge SYS_CLK);
        ARM_A     = 24'd0;
        ARM_RW    = 1'b0;
        ARM_D_IN  = 32'hFFFF_FFFF;
        ARM_BE_B  = 4'b0000;
        ARM_CS1_B = 1'b0;
        wait_cycles(2);
        ARM_CS1_B = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge SYS_CLK);
            if (ARM_DTACK) seen = 1'b1;
        end
        check("abort_no_dtack", 32'(seen), 32'd0);
        rd_chk("abort_no_write", 0);

        // Reset while in ACK with CS still low.
        @(negedge SYS_CLK);
        ARM_A     = {19'd0, 3'd6, 2'd0};
        ARM_RW    = 1'b1;
        ARM_OE_B  = 1'b0;
        ARM_CS1_B = 1'b0;
        n = 0;
        while (!ARM_DTACK && n < 40) begin
            @(negedge SYS_CLK);
            n++;
        end
        check("mid_ack_reached", 32'(ARM_DTACK), 32'd1);
        SYS_RST_N = 1'b0;
        @(negedge SYS_CLK);
        check("mid_rst_dtack", 32'(ARM_DTACK), 32'd0);
        check("mid_rst_d_oe",  32'(ARM_D_OE),  32'd0);
        SYS_RST_N = 1'b1;
        model_reset();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge SYS_CLK);
            if (ARM_DTACK) seen = 1'b1;
        end
        check("release_holds", 32'(seen), 32'd0);
        ARM_CS1_B = 1'b1;
        ARM_OE_B  = 1'b1;
        wait_cycles(4);
        rd_chk("post_rst_id", 6);
        rd_chk("post_rst_scratch", 0);
        rd_chk("post_rst_cycle_cnt", 5);
        check("post_rst_led", 32'(LED), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
